// File: rtl/ble_crc_whitener.sv
// BLE TX bit stage: CRC-24 over payload bits, appends the CRC, optional whitening.
// Ports: clk/reset, start+seeds (crc_init, channel, whiten_en),
//   serial in (bit_in, valid_in, last_in, ready), serial out (bit_out, valid_out),
//   status (busy, done, overflow).
module ble_crc_whitener #(
  parameter int MAX_BITS = 2056,
  parameter int CNT_W    = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] crc_init,
  input  logic [5:0]  channel,
  input  logic        whiten_en,
  input  logic        bit_in,
  input  logic        valid_in,
  input  logic        last_in,
  output logic        ready,
  output logic        bit_out,
  output logic        valid_out,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAYLOAD,
    S_CRC
  } state_t;

  state_t           r_state;
  logic [23:0]      r_crc;
  logic [6:0]       r_lfsr;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_idx;
  logic             r_whiten;
  logic             r_bit;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_ovf;

  logic             w_wbit;
  logic             w_fb;
  logic             w_at_max;
  logic [6:0]       w_lfsr_nxt;
  logic [23:0]      w_crc_nxt;

  assign w_wbit     = r_whiten & r_lfsr[0];
  assign w_fb       = bit_in ^ r_crc[23];
  assign w_at_max   = (r_cnt == CNT_W'(MAX_BITS));
  // x^7 + x^4 + 1, bit 0 is the whitening output
  assign w_lfsr_nxt = {r_lfsr[0], r_lfsr[6], r_lfsr[5],
                       r_lfsr[4] ^ r_lfsr[0],
                       r_lfsr[3], r_lfsr[2], r_lfsr[1]};
  assign w_crc_nxt  = {r_crc[22:0], 1'b0}
                    ^ (w_fb ? 24'h00065B : 24'h000000);

  assign ready     = (r_state == S_PAYLOAD);
  assign bit_out   = r_bit;
  assign valid_out = r_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign overflow  = r_ovf;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_crc    <= '0;
      r_lfsr   <= '0;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_whiten <= 1'b0;
      r_bit    <= 1'b0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          // busy stays high through the done cycle, drops one later
          r_busy <= 1'b0;
          if (start) begin
            r_crc    <= crc_init;
            r_lfsr   <= {1'b1, channel};
            r_whiten <= whiten_en;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (valid_in) begin
            if (w_at_max) begin
              // bit dropped: no output, CRC and LFSR hold
              r_ovf <= 1'b1;
            end else begin
              r_crc   <= w_crc_nxt;
              r_bit   <= bit_in ^ w_wbit;
              r_valid <= 1'b1;
              r_lfsr  <= w_lfsr_nxt;
              r_cnt   <= r_cnt + CNT_W'(1);
            end
            if (last_in) begin
              r_idx   <= 5'd23;
              r_state <= S_CRC;
            end
          end
        end
        S_CRC: begin
          r_bit   <= r_crc[23] ^ w_wbit;
          r_valid <= 1'b1;
          r_crc   <= {r_crc[22:0], 1'b0};
          r_lfsr  <= w_lfsr_nxt;
          if (r_idx == 5'd0) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_idx <= r_idx - 5'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
